// File: rtl/tmr_fault_manager_pkg.sv
// Shared types for the TMR fault manager: FSM states, core indices and the fault vector type.
// Imported by tmr_fault_manager and tmr_recovery_counter.
package tmr_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CONFIRM,
        STALL,
        RESET,
        RELEASE,
        FATAL
    } tmr_state_t;

    localparam int CORE_A = 2;
    localparam int CORE_B = 1;
    localparam int CORE_C = 0;

    typedef logic [2:0] fault_vec_t;

    // Two or more simultaneous faults leave the voter without a majority.
    function automatic logic [1:0] popcount3(input fault_vec_t v);
        return {1'b0, v[CORE_A]} + {1'b0, v[CORE_B]} + {1'b0, v[CORE_C]};
    endfunction

endpackage

// File: rtl/tmr_recovery_counter.sv
// Per-core 8-bit saturating recovery counter with synchronous clear.
// o_dead is a sticky registered flag raised once the count reaches MAX_RECOVERIES.
module tmr_recovery_counter
    import tmr_pkg::*;
#(
    parameter int MAX_RECOVERIES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clear,
    input  logic       i_inc,
    output logic [7:0] o_count,
    output logic       o_dead
);

    logic [7:0] r_count;
    logic       r_dead;
    logic [7:0] w_count_next;

    assign w_count_next = (r_count == 8'hFF) ? r_count : r_count + 8'd1;

    // The dead flag is evaluated against the post-increment value so it rises together with the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_dead  <= 1'b0;
        end else if (i_clear) begin
            r_count <= '0;
            r_dead  <= 1'b0;
        end else if (i_inc) begin
            r_count <= w_count_next;
            r_dead  <= r_dead | ({24'd0, w_count_next} >= 32'(MAX_RECOVERIES));
        end
    end

    assign o_count = r_count;
    assign o_dead  = r_dead;

endmodule

// File: rtl/tmr_fault_manager.sv
// Debounces TMR voter fault flags, stalls the cluster and pulses reset into the single faulty core.
// Define TMR_FM_TIMESTAMP_EN to build a cycle counter that stamps each confirmed fault.
module tmr_fault_manager
    import tmr_pkg::*;
#(
    parameter int PERSIST_CYCLES = 4,
    parameter int RESET_CYCLES   = 16,
    parameter int MAX_RECOVERIES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  fault_flags_i,
    input  logic        disagreement_i,
    input  logic        clear_i,
    output logic [2:0]  core_rst_n_o,
    output logic        stall_o,
    output logic [2:0]  core_dead_o,
    output logic        fatal_o,
    output logic        irq_o,
    output logic [23:0] recov_cnt_o,
    output logic [15:0] transient_cnt_o,
    output logic [31:0] last_fault_ts_o
);

    localparam logic [7:0]  PERSIST_LAST = 8'(PERSIST_CYCLES - 1);
    localparam logic [15:0] RESET_LOAD   = 16'(RESET_CYCLES - 1);

    tmr_state_t r_state;
    tmr_state_t w_state_next;
    fault_vec_t r_vec;
    fault_vec_t w_vec_next;
    fault_vec_t r_target;
    fault_vec_t w_target_next;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_next;
    logic [15:0] r_timer;
    logic [15:0] w_timer_next;

    logic [2:0]  r_core_rst_n;
    logic        r_stall;
    logic        r_fatal;
    logic        r_irq;
    logic [15:0] r_trans;

    fault_vec_t w_mask;
    logic [2:0] w_dead;
    logic [2:0] w_recov_inc;
    logic       w_confirm;
    logic       w_trans_inc;
    logic       w_clear;

    // The voter's disagreement line carries no extra information once the per-core flags are debounced.
    logic w_unused_disagreement;
    assign w_unused_disagreement = disagreement_i;

    assign w_mask = fault_flags_i & ~w_dead;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_vec    <= '0;
            r_cnt    <= '0;
            r_timer  <= '0;
            r_target <= '0;
        end else begin
            r_state  <= w_state_next;
            r_vec    <= w_vec_next;
            r_cnt    <= w_cnt_next;
            r_timer  <= w_timer_next;
            r_target <= w_target_next;
        end
    end

    // Flags are only looked at in IDLE and CONFIRM; clear only in IDLE and FATAL.
    always_comb begin
        w_state_next  = r_state;
        w_vec_next    = r_vec;
        w_cnt_next    = r_cnt;
        w_timer_next  = r_timer;
        w_target_next = r_target;
        w_recov_inc   = '0;
        w_confirm     = 1'b0;
        w_trans_inc   = 1'b0;
        w_clear       = 1'b0;

        case (r_state)
            IDLE: begin
                if (clear_i) begin
                    w_clear = 1'b1;
                end else if (w_mask != '0) begin
                    w_vec_next   = w_mask;
                    w_cnt_next   = 8'd1;
                    w_state_next = CONFIRM;
                end
            end
            CONFIRM: begin
                if (w_mask == '0) begin
                    w_trans_inc  = 1'b1;
                    w_state_next = IDLE;
                end else if (w_mask != r_vec) begin
                    w_vec_next = w_mask;
                    w_cnt_next = 8'd1;
                end else if (r_cnt >= PERSIST_LAST) begin
                    w_confirm  = 1'b1;
                    w_cnt_next = r_cnt + 8'd1;
                    if ((popcount3(r_vec) >= 2'd2) || (w_dead != '0)) begin
                        w_state_next = FATAL;
                    end else begin
                        w_target_next = r_vec;
                        w_state_next  = STALL;
                    end
                end else begin
                    w_cnt_next = r_cnt + 8'd1;
                end
            end
            STALL: begin
                w_recov_inc  = r_target;
                w_timer_next = RESET_LOAD;
                w_state_next = RESET;
            end
            RESET: begin
                if (r_timer == '0) begin
                    w_timer_next = 16'd1;
                    w_state_next = RELEASE;
                end else begin
                    w_timer_next = r_timer - 16'd1;
                end
            end
            RELEASE: begin
                if (r_timer == '0) begin
                    w_state_next = IDLE;
                end else begin
                    w_timer_next = r_timer - 16'd1;
                end
            end
            FATAL: begin
                if (clear_i) begin
                    w_clear      = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so every port comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_core_rst_n <= 3'b111;
            r_stall      <= 1'b0;
            r_fatal      <= 1'b0;
            r_irq        <= 1'b0;
            r_trans      <= '0;
        end else begin
            r_core_rst_n <= (w_state_next == RESET) ? ~w_target_next : 3'b111;
            r_stall      <= (w_state_next != IDLE) && (w_state_next != CONFIRM);
            r_fatal      <= (w_state_next == FATAL);
            r_irq        <= ((r_state == RELEASE) && (w_state_next == IDLE)) ||
                            ((r_state != FATAL) && (w_state_next == FATAL));
            if (w_clear) begin
                r_trans <= '0;
            end else if (w_trans_inc && (r_trans != 16'hFFFF)) begin
                r_trans <= r_trans + 16'd1;
            end
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_core
        tmr_recovery_counter #(
            .MAX_RECOVERIES(MAX_RECOVERIES)
        ) u_recovery_counter (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_clear (w_clear),
            .i_inc   (w_recov_inc[gi]),
            .o_count (recov_cnt_o[gi*8 +: 8]),
            .o_dead  (w_dead[gi])
        );
    end

`ifdef TMR_FM_TIMESTAMP_EN
    logic [31:0] r_cycle;
    logic [31:0] r_last_ts;

    // Free-running counter; its pre-increment value is the timestamp of a confirming edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle   <= '0;
            r_last_ts <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (w_confirm) begin
                r_last_ts <= r_cycle;
            end
        end
    end

    assign last_fault_ts_o = r_last_ts;
`else
    logic w_unused_confirm;
    assign w_unused_confirm = w_confirm;
    assign last_fault_ts_o  = '0;
`endif

    assign core_rst_n_o    = r_core_rst_n;
    assign stall_o         = r_stall;
    assign core_dead_o     = w_dead;
    assign fatal_o         = r_fatal;
    assign irq_o           = r_irq;
    assign transient_cnt_o = r_trans;

endmodule

// File: tb/tb_tmr_fault_manager.sv
// Self-checking bench for tmr_fault_manager: directed scenarios plus randomized flags against a schedule-based model.
// Honours TMR_FM_TIMESTAMP_EN when predicting last_fault_ts_o.
module tb_tmr_fault_manager;

    localparam int P    = 4;
    localparam int RC   = 16;
    localparam int MAXR = 3;

    localparam logic [80:0] RESET_VEC = {3'b111, 1'b0, 3'b000, 1'b0, 1'b0, 24'd0, 16'd0, 32'd0};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  fault_flags_i;
    logic        disagreement_i;
    logic        clear_i;
    logic [2:0]  core_rst_n_o;
    logic        stall_o;
    logic [2:0]  core_dead_o;
    logic        fatal_o;
    logic        irq_o;
    logic [23:0] recov_cnt_o;
    logic [15:0] transient_cnt_o;
    logic [31:0] last_fault_ts_o;

    always #5 clk = ~clk;

    tmr_fault_manager #(
        .PERSIST_CYCLES(P),
        .RESET_CYCLES  (RC),
        .MAX_RECOVERIES(MAXR)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fault_flags_i  (fault_flags_i),
        .disagreement_i (disagreement_i),
        .clear_i        (clear_i),
        .core_rst_n_o   (core_rst_n_o),
        .stall_o        (stall_o),
        .core_dead_o    (core_dead_o),
        .fatal_o        (fatal_o),
        .irq_o          (irq_o),
        .recov_cnt_o    (recov_cnt_o),
        .transient_cnt_o(transient_cnt_o),
        .last_fault_ts_o(last_fault_ts_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a recovery is a precomputed schedule of output cycles, not a state machine.
    typedef struct packed {
        logic [2:0] rst_n;
        logic       stall;
        logic       irq;
        logic       bump;
    } step_t;

    step_t       sched[$];
    bit          m_deb;
    logic [2:0]  m_vec;
    int          m_cnt;
    bit          m_fatal;
    int          m_recov[3];
    logic [2:0]  m_dead;
    int          m_trans;
    int          m_tidx;
    logic [31:0] m_cyc;
    logic [31:0] m_ts;
    logic [2:0]  e_rst;
    logic        e_stall;
    logic        e_irq;

    function automatic void model_clear_counts();
        for (int k = 0; k < 3; k++) m_recov[k] = 0;
        m_dead  = '0;
        m_trans = 0;
        m_fatal = 1'b0;
    endfunction

    function automatic void model_reset();
        model_clear_counts();
        sched.delete();
        m_deb   = 1'b0;
        m_vec   = '0;
        m_cnt   = 0;
        m_tidx  = 0;
        m_cyc   = '0;
        m_ts    = '0;
        e_rst   = 3'b111;
        e_stall = 1'b0;
        e_irq   = 1'b0;
    endfunction

    function automatic void model_step(input logic [2:0] flags, input bit clr);
        logic [2:0] m;
        step_t s;
        e_irq = 1'b0;
        if (m_fatal) begin
            e_rst = 3'b111;
            if (clr) begin
                model_clear_counts();
                e_stall = 1'b0;
            end else begin
                e_stall = 1'b1;
            end
        end else if (sched.size() > 0) begin
            s       = sched.pop_front();
            e_rst   = s.rst_n;
            e_stall = s.stall;
            e_irq   = s.irq;
            if (s.bump) begin
                if (m_recov[m_tidx] < 255) m_recov[m_tidx]++;
                if (m_recov[m_tidx] >= MAXR) m_dead[m_tidx] = 1'b1;
            end
        end else begin
            e_rst   = 3'b111;
            e_stall = 1'b0;
            m = flags & ~m_dead;
            if (!m_deb) begin
                if (clr) model_clear_counts();
                else if (m != 3'b000) begin
                    m_deb = 1'b1;
                    m_vec = m;
                    m_cnt = 1;
                end
            end else if (m == 3'b000) begin
                m_deb = 1'b0;
                if (m_trans < 65535) m_trans++;
            end else if (m != m_vec) begin
                m_vec = m;
                m_cnt = 1;
            end else begin
                m_cnt++;
                if (m_cnt == P) begin
                    m_deb   = 1'b0;
                    m_ts    = m_cyc;
                    e_stall = 1'b1;
                    if ($countones(m_vec) >= 2 || m_dead != 3'b000) begin
                        m_fatal = 1'b1;
                        e_irq   = 1'b1;
                    end else begin
                        for (int k = 0; k < 3; k++) if (m_vec[k]) m_tidx = k;
                        for (int k = 0; k < RC; k++) sched.push_back({~m_vec, 1'b1, 1'b0, (k == 0)});
                        sched.push_back({3'b111, 1'b1, 1'b0, 1'b0});
                        sched.push_back({3'b111, 1'b1, 1'b0, 1'b0});
                        sched.push_back({3'b111, 1'b0, 1'b1, 1'b0});
                    end
                end
            end
        end
        m_cyc = m_cyc + 32'd1;
    endfunction

    function automatic logic [80:0] obs();
        return {core_rst_n_o, stall_o, core_dead_o, fatal_o, irq_o,
                recov_cnt_o, transient_cnt_o, last_fault_ts_o};
    endfunction

    function automatic logic [80:0] exp_vec();
        logic [31:0] ts;
`ifdef TMR_FM_TIMESTAMP_EN
        ts = m_ts;
`else
        ts = '0;
`endif
        return {e_rst, e_stall, m_dead, m_fatal, e_irq,
                8'(m_recov[2]), 8'(m_recov[1]), 8'(m_recov[0]), 16'(m_trans), ts};
    endfunction

    task automatic tick(input logic [2:0] flags, input logic dis, input logic clr);
        fault_flags_i  = flags;
        disagreement_i = dis;
        clear_i        = clr;
        @(posedge clk);
        model_step(flags, clr);
        #1;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        fault_flags_i  = 3'b000;
        disagreement_i = 1'b0;
        clear_i        = 1'b0;
        #12;
        n_cmp++;
        if (obs() !== RESET_VEC) begin
            n_bad++;
            $display("[TB] FAIL reset_values: got %h expected %h", obs(), RESET_VEC);
        end
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_single_fault();
        int stall_n = 0;
        int low_n   = 0;
        int irq_n   = 0;
        for (int i = 0; i < 30; i++) begin
            tick((i < 6) ? 3'b100 : 3'b000, 1'b0, 1'b0);
            n_cmp++;
            if (obs() !== exp_vec()) begin
                n_bad++;
                $display("[TB] FAIL single_fault cycle %0d: got %h expected %h", i, obs(), exp_vec());
            end
            stall_n += int'(stall_o);
            irq_n   += int'(irq_o);
            if (core_rst_n_o == 3'b011) low_n++;
        end
        n_cmp++;
        if (stall_n !== 1 + RC + 2) begin
            n_bad++;
            $display("[TB] FAIL single_fault_stall_len: got %0d expected %0d", stall_n, 1 + RC + 2);
        end
        n_cmp++;
        if (low_n !== RC) begin
            n_bad++;
            $display("[TB] FAIL single_fault_reset_len: got %0d expected %0d", low_n, RC);
        end
        n_cmp++;
        if (irq_n !== 1 || recov_cnt_o[23:16] !== 8'd1) begin
            n_bad++;
            $display("[TB] FAIL single_fault_irq_recov: got irq=%0d recovA=%0d expected 1/1", irq_n, recov_cnt_o[23:16]);
        end
    endtask

    task automatic test_transient();
        bit saw_stall = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick((i < 2) ? 3'b010 : 3'b000, 1'b1, 1'b0);
            n_cmp++;
            if (obs() !== exp_vec()) begin
                n_bad++;
                $display("[TB] FAIL transient cycle %0d: got %h expected %h", i, obs(), exp_vec());
            end
            saw_stall |= stall_o;
        end
        n_cmp++;
        if (saw_stall !== 1'b0 || transient_cnt_o !== 16'd1) begin
            n_bad++;
            $display("[TB] FAIL transient_reject: got stall_seen=%0b count=%0d expected 0/1", saw_stall, transient_cnt_o);
        end
    endtask

    task automatic test_fault_moves();
        bit hit_other = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick((i < 2) ? 3'b001 : ((i < 6) ? 3'b100 : 3'b000), 1'b0, 1'b0);
            n_cmp++;
            if (obs() !== exp_vec()) begin
                n_bad++;
                $display("[TB] FAIL fault_moves cycle %0d: got %h expected %h", i, obs(), exp_vec());
            end
            if (core_rst_n_o != 3'b111 && core_rst_n_o != 3'b011) hit_other = 1'b1;
            if (i == 4 && stall_o !== 1'b0) begin
                n_bad++;
                $display("[TB] FAIL fault_moves_restart: got stall=%0b expected 0", stall_o);
            end
            if (i == 5 && stall_o !== 1'b1) begin
                n_bad++;
                $display("[TB] FAIL fault_moves_confirm: got stall=%0b expected 1", stall_o);
            end
            if (i == 4 || i == 5) n_cmp++;
        end
        n_cmp++;
        if (hit_other || recov_cnt_o[23:16] !== 8'd2 || recov_cnt_o[7:0] !== 8'd0) begin
            n_bad++;
            $display("[TB] FAIL fault_moves_target: got other=%0b recovA=%0d recovC=%0d expected 0/2/0",
                     hit_other, recov_cnt_o[23:16], recov_cnt_o[7:0]);
        end
    endtask

    task automatic test_retirement();
        bit saw_stall = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < RC + 8; i++) begin
                tick((i < 4) ? 3'b010 : 3'b000, 1'b0, 1'b0);
                n_cmp++;
                if (obs() !== exp_vec()) begin
                    n_bad++;
                    $display("[TB] FAIL retire_run%0d cycle %0d: got %h expected %h", r, i, obs(), exp_vec());
                end
            end
        end
        n_cmp++;
        if (core_dead_o !== 3'b010) begin
            n_bad++;
            $display("[TB] FAIL retire_dead: got %b expected 010", core_dead_o);
        end
        for (int i = 0; i < 6; i++) begin
            tick(3'b010, 1'b1, 1'b0);
            saw_stall |= stall_o;
        end
        n_cmp++;
        if (saw_stall !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL retire_ignored: got stall_seen=%0b expected 0", saw_stall);
        end
        for (int i = 0; i < 8; i++) begin
            tick((i < 4) ? 3'b100 : 3'b000, 1'b0, 1'b0);
            n_cmp++;
            if (obs() !== exp_vec()) begin
                n_bad++;
                $display("[TB] FAIL retire_fatal cycle %0d: got %h expected %h", i, obs(), exp_vec());
            end
        end
        n_cmp++;
        if (fatal_o !== 1'b1 || stall_o !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL retire_fatal_held: got fatal=%0b stall=%0b expected 1/1", fatal_o, stall_o);
        end
        tick(3'b000, 1'b0, 1'b1);
        n_cmp++;
        if ({core_dead_o, fatal_o, stall_o, recov_cnt_o, transient_cnt_o} !== 46'd0) begin
            n_bad++;
            $display("[TB] FAIL retire_clear: got dead=%b fatal=%0b stall=%0b recov=%h trans=%0d expected all zero",
                     core_dead_o, fatal_o, stall_o, recov_cnt_o, transient_cnt_o);
        end
    endtask

    task automatic test_double_fault();
        logic [31:0] conf_cyc;
        logic [31:0] want_ts;
        for (int i = 0; i < 4; i++) begin
            tick(3'b110, 1'b1, 1'b0);
            conf_cyc = m_cyc - 32'd1;
        end
        n_cmp++;
        if (fatal_o !== 1'b1 || irq_o !== 1'b1 || stall_o !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL double_fatal: got fatal=%0b irq=%0b stall=%0b expected 1/1/1", fatal_o, irq_o, stall_o);
        end
`ifdef TMR_FM_TIMESTAMP_EN
        want_ts = conf_cyc;
`else
        want_ts = '0;
`endif
        n_cmp++;
        if (last_fault_ts_o !== want_ts) begin
            n_bad++;
            $display("[TB] FAIL double_timestamp: got %0d expected %0d", last_fault_ts_o, want_ts);
        end
        for (int i = 0; i < 3; i++) begin
            tick(3'b000, 1'b0, (i == 2));
            n_cmp++;
            if (obs() !== exp_vec()) begin
                n_bad++;
                $display("[TB] FAIL double_hold cycle %0d: got %h expected %h", i, obs(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_midsequence();
        for (int i = 0; i < 9; i++) tick((i < 4) ? 3'b001 : 3'b000, 1'b0, 1'b0);
        n_cmp++;
        if (core_rst_n_o !== 3'b110) begin
            n_bad++;
            $display("[TB] FAIL midreset_in_reset: got %b expected 110", core_rst_n_o);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs() !== RESET_VEC) begin
            n_bad++;
            $display("[TB] FAIL midreset_restore: got %h expected %h", obs(), RESET_VEC);
        end
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [2:0] f = 3'b000;
        int hold = 0;
        bit c;
        for (int i = 0; i < 1500; i++) begin
            if (hold == 0) begin
                f    = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
                hold = $urandom_range(1, 8);
            end
            hold--;
            c = ($urandom_range(0, 15) == 0);
            tick(f, 1'($urandom_range(0, 1)), c);
            n_cmp++;
            if (obs() !== exp_vec()) begin
                n_bad++;
                $display("[TB] FAIL random cycle %0d flags=%b clr=%0b: got %h expected %h", i, f, c, obs(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_fault();
        test_transient();
        test_fault_moves();
        test_retirement();
        test_double_fault();
        test_reset_midsequence();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
